stream_rr_arbiter: RTL and testbench



---
 rtl/stream_arb_pkg.sv | 14 +
 rtl/rr_prio_sel.sv | 32 +++
 rtl/stream_rr_arbiter.sv | 108 ++++++++++
 tb/tb_stream_rr_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared types and helpers for the stream round-robin arbiter
package stream_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK  = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    function automatic int unsigned idx_wrap_inc(input int unsigned idx, input int unsigned num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_prio_sel.sv
// rtl/rr_prio_sel.sv - combinational rotating-priority picker: first request at or after the pointer
module rr_prio_sel #(
    parameter int unsigned NumInp   = 4,
    parameter int unsigned IdxWidth = $clog2(NumInp)
) (
    input  logic [NumInp-1:0]   i_req,
    input  logic [IdxWidth-1:0] i_ptr,
    output logic [IdxWidth-1:0] o_idx,
    output logic                o_any
);

    logic        w_found;
    int unsigned w_j;

    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int unsigned k = 0; k < NumInp; k++) begin
            w_j = 32'(i_ptr) + k;
            if (w_j >= NumInp) begin
                w_j = w_j - NumInp;
            end
            if (!w_found && i_req[IdxWidth'(w_j)]) begin
                o_idx   = IdxWidth'(w_j);
                w_found = 1'b1;
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin stream arbiter with grant locking and optional bursts
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter type         data_t   = logic,
    parameter int unsigned NumInp   = 4,
    parameter int unsigned MaxBurst = 1,
    parameter int unsigned IdxWidth = $clog2(NumInp)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  data_t               inp_data_i  [NumInp],
    input  logic [NumInp-1:0]   inp_valid_i,
    output logic [NumInp-1:0]   inp_ready_o,
    output data_t               oup_data_o,
    output logic                oup_valid_o,
    input  logic                oup_ready_i,
    output logic [IdxWidth-1:0] oup_idx_o
);

    localparam int unsigned CntWidth = $clog2(MaxBurst + 1);

    arb_state_e            r_state, w_state_nxt;
    logic [IdxWidth-1:0]   r_ptr, w_ptr_nxt;
    logic [IdxWidth-1:0]   r_lidx, w_lidx_nxt;
    logic [CntWidth-1:0]   r_cnt, w_cnt_nxt;

    logic                  w_relinq;
    logic                  w_locked;
    logic [IdxWidth-1:0]   w_rr_ptr;
    logic [IdxWidth-1:0]   w_rr_idx;
    logic                  w_any;
    logic [IdxWidth-1:0]   w_sel;
    logic                  w_valid;
    logic                  w_hs;
    logic [CntWidth-1:0]   w_cnt_base;
    logic [CntWidth-1:0]   w_cnt_inc;

    // A burst owner that drops valid hands the pointer on and arbitration happens in the same cycle.
    assign w_relinq = (r_state == BURST) && !inp_valid_i[r_lidx];
    assign w_locked = (r_state == LOCK) || ((r_state == BURST) && inp_valid_i[r_lidx]);
    assign w_rr_ptr = w_relinq ? IdxWidth'(idx_wrap_inc(32'(r_lidx), NumInp)) : r_ptr;

    rr_prio_sel #(
        .NumInp   (NumInp),
        .IdxWidth (IdxWidth)
    ) u_prio_sel (
        .i_req (inp_valid_i),
        .i_ptr (w_rr_ptr),
        .o_idx (w_rr_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lidx_nxt  = r_lidx;
        w_cnt_nxt   = r_cnt;

        w_sel      = w_locked ? r_lidx : w_rr_idx;
        w_valid    = w_locked ? inp_valid_i[r_lidx] : w_any;
        w_cnt_base = w_locked ? r_cnt : '0;
        w_cnt_inc  = w_cnt_base + CntWidth'(1);
        w_hs       = w_valid && oup_ready_i;

        if (w_relinq) begin
            w_ptr_nxt   = w_rr_ptr;
            w_cnt_nxt   = '0;
            w_state_nxt = ARB;
        end

        if (w_hs) begin
            if (w_cnt_inc == CntWidth'(MaxBurst)) begin
                w_ptr_nxt   = IdxWidth'(idx_wrap_inc(32'(w_sel), NumInp));
                w_cnt_nxt   = '0;
                w_state_nxt = ARB;
            end else begin
                w_lidx_nxt  = w_sel;
                w_cnt_nxt   = w_cnt_inc;
                w_state_nxt = BURST;
            end
        end else if (w_valid && !w_locked) begin
            w_lidx_nxt  = w_sel;
            w_state_nxt = LOCK;
        end

        oup_valid_o        = w_valid && !rst_i;
        oup_data_o         = inp_data_i[w_sel];
        oup_idx_o          = w_sel;
        inp_ready_o        = '0;
        inp_ready_o[w_sel] = oup_ready_i && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB;
            r_ptr   <= '0;
            r_lidx  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lidx  <= w_lidx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - directed and randomized checks of stream_rr_arbiter (MaxBurst 1 and 3)
module tb_stream_rr_arbiter;

    logic       clk;
    logic       rst;

    logic [7:0] d1 [4];
    logic [3:0] v1, r1;
    logic [7:0] od1;
    logic       ov1, rdy1;
    logic [1:0] oi1;

    logic [7:0] d3 [4];
    logic [3:0] v3, r3;
    logic [7:0] od3;
    logic       ov3, rdy3;
    logic [1:0] oi3;

    int n_cmp = 0;
    int n_bad = 0;

    stream_rr_arbiter #(.data_t(logic [7:0]), .NumInp(4), .MaxBurst(1)) dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .inp_data_i  (d1),
        .inp_valid_i (v1),
        .inp_ready_o (r1),
        .oup_data_o  (od1),
        .oup_valid_o (ov1),
        .oup_ready_i (rdy1),
        .oup_idx_o   (oi1)
    );

    stream_rr_arbiter #(.data_t(logic [7:0]), .NumInp(4), .MaxBurst(3)) dut3 (
        .clk_i       (clk),
        .rst_i       (rst),
        .inp_data_i  (d3),
        .inp_valid_i (v3),
        .inp_ready_o (r3),
        .oup_data_o  (od3),
        .oup_valid_o (ov3),
        .oup_ready_i (rdy3),
        .oup_idx_o   (oi3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        v1   = '0;
        v3   = '0;
        rdy1 = 1'b0;
        rdy3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst  = 1'b1;
        v1   = 4'hF;
        v3   = 4'hF;
        rdy1 = 1'b1;
        rdy3 = 1'b1;
        #2;
        n_cmp++; if (ov1 !== 1'b0) begin n_bad++; $display("FAIL reset_valid1 got %b want 0", ov1); end
        n_cmp++; if (r1 !== 4'b0000) begin n_bad++; $display("FAIL reset_ready1 got %b want 0000", r1); end
        n_cmp++; if (ov3 !== 1'b0) begin n_bad++; $display("FAIL reset_valid3 got %b want 0", ov3); end
        n_cmp++; if (r3 !== 4'b0000) begin n_bad++; $display("FAIL reset_ready3 got %b want 0000", r3); end
        @(negedge clk);
        rst = 1'b0;
        v1  = '0;
        v3  = '0;
        #2;
        n_cmp++; if (ov1 !== 1'b0) begin n_bad++; $display("FAIL idle_valid1 got %b want 0", ov1); end
        n_cmp++; if (ov3 !== 1'b0) begin n_bad++; $display("FAIL idle_valid3 got %b want 0", ov3); end
    endtask

    task automatic test_rr_order();
        logic [1:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) d1[i] = 8'h10 + 8'(i);
        v1   = 4'hF;
        rdy1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = 2'(k % 4);
            #2;
            n_cmp++; if (oi1 !== e) begin n_bad++; $display("FAIL rr_idx beat %0d got %0d want %0d", k, oi1, e); end
            n_cmp++; if (od1 !== 8'h10 + 8'(e)) begin n_bad++; $display("FAIL rr_data beat %0d got %h want %h", k, od1, 8'h10 + 8'(e)); end
            n_cmp++; if (r1 !== 4'(1 << e) || ov1 !== 1'b1) begin n_bad++; $display("FAIL rr_ready beat %0d got %b/%b want %b/1", k, r1, ov1, 4'(1 << e)); end
            @(negedge clk);
        end
        v1 = '0;
    endtask

    task automatic test_lock();
        logic [1:0] e;
        for (int var_i = 0; var_i < 2; var_i++) begin
            do_reset();
            for (int i = 0; i < 4; i++) d1[i] = 8'h20 + 8'(i);
            v1   = 4'b0100;
            rdy1 = 1'b0;
            for (int c = 0; c < 6; c++) begin
                if (c == 5) begin
                    v1[0] = 1'b1;
                    if (var_i == 1) v1[3] = 1'b1;
                end
                #2;
                n_cmp++; if (oi1 !== 2'd2 || od1 !== 8'h22 || ov1 !== 1'b1) begin n_bad++; $display("FAIL lock_hold cycle %0d got idx %0d data %h valid %b want 2/22/1", c, oi1, od1, ov1); end
                n_cmp++; if (r1 !== 4'b0000) begin n_bad++; $display("FAIL lock_ready cycle %0d got %b want 0000", c, r1); end
                @(negedge clk);
            end
            rdy1 = 1'b1;
            #2;
            n_cmp++; if (r1 !== 4'b0100 || oi1 !== 2'd2) begin n_bad++; $display("FAIL lock_hs got ready %b idx %0d want 0100/2", r1, oi1); end
            @(negedge clk);
            v1[2] = 1'b0;
            e = (var_i == 1) ? 2'd3 : 2'd0;
            #2;
            n_cmp++; if (oi1 !== e) begin n_bad++; $display("FAIL lock_next var %0d got %0d want %0d", var_i, oi1, e); end
            @(negedge clk);
            v1 = '0;
        end
    endtask

    task automatic test_burst();
        int exp_a [9] = '{1, 1, 1, 3, 3, 3, 1, 1, 1};
        int exp_b [6] = '{1, 1, 3, 3, 3, 1};
        do_reset();
        for (int i = 0; i < 4; i++) d3[i] = 8'h30 + 8'(i);
        v3   = 4'b1010;
        rdy3 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #2;
            n_cmp++; if (oi3 !== 2'(exp_a[k]) || ov3 !== 1'b1) begin n_bad++; $display("FAIL burst_seq beat %0d got %0d want %0d", k, oi3, exp_a[k]); end
            @(negedge clk);
        end
        do_reset();
        v3   = 4'b1010;
        rdy3 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) v3[1] = 1'b0;
            if (k == 3) v3[1] = 1'b1;
            #2;
            n_cmp++; if (oi3 !== 2'(exp_b[k]) || ov3 !== 1'b1) begin n_bad++; $display("FAIL burst_drop beat %0d got %0d want %0d", k, oi3, exp_b[k]); end
            @(negedge clk);
        end
        v3 = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int i = 0; i < 4; i++) d3[i] = 8'h40 + 8'(i);
        v3   = 4'b0100;
        rdy3 = 1'b1;
        #2;
        n_cmp++; if (oi3 !== 2'd2) begin n_bad++; $display("FAIL midrst_first got %0d want 2", oi3); end
        @(negedge clk);
        rdy3 = 1'b0;
        #2;
        n_cmp++; if (oi3 !== 2'd2 || r3 !== 4'b0000) begin n_bad++; $display("FAIL midrst_lock got idx %0d ready %b want 2/0000", oi3, r3); end
        @(negedge clk);
        rst  = 1'b1;
        v3   = 4'hF;
        rdy3 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_cmp++; if (ov3 !== 1'b0 || r3 !== 4'b0000) begin n_bad++; $display("FAIL midrst_quiet cycle %0d got valid %b ready %b want 0/0000", c, ov3, r3); end
            @(negedge clk);
        end
        rst = 1'b0;
        #2;
        n_cmp++; if (oi3 !== 2'd0 || r3 !== 4'b0001 || ov3 !== 1'b1) begin n_bad++; $display("FAIL midrst_after got idx %0d ready %b valid %b want 0/0001/1", oi3, r3, ov3); end
        @(negedge clk);
        v3 = '0;
    endtask

    task automatic test_random();
        int         tx_seq [4];
        int         rx_seq [4];
        int         waitb [4];
        int         hs_idx;
        int         wl;
        logic       prev_stall;
        logic [1:0] prev_idx;
        logic [7:0] prev_data;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tx_seq[i] = 0;
            rx_seq[i] = 0;
            waitb[i]  = 0;
        end
        hs_idx     = -1;
        wl         = 0;
        prev_stall = 1'b0;
        prev_idx   = '0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (hs_idx >= 0) begin
                v3[hs_idx] = 1'b0;
                tx_seq[hs_idx]++;
                hs_idx = -1;
            end
            for (int i = 0; i < 4; i++) begin
                if (!v3[i] && $urandom_range(0, 2) != 0) begin
                    v3[i] = 1'b1;
                    d3[i] = {2'(i), 6'(tx_seq[i])};
                end
            end
            if (wl == 0) begin
                rdy3 = 1'b1;
            end else begin
                rdy3 = 1'b0;
                wl--;
            end
            #2;
            if (prev_stall) begin
                n_cmp++; if (oi3 !== prev_idx || od3 !== prev_data || ov3 !== 1'b1) begin n_bad++; $display("FAIL rnd_stable cyc %0d got %0d/%h want %0d/%h", cyc, oi3, od3, prev_idx, prev_data); end
            end
            if (ov3 && rdy3) begin
                n_cmp++; if (od3 !== {oi3, 6'(rx_seq[oi3])}) begin n_bad++; $display("FAIL rnd_order cyc %0d got %h want %h", cyc, od3, {oi3, 6'(rx_seq[oi3])}); end
                n_cmp++; if (r3 !== 4'(1 << oi3)) begin n_bad++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, r3, 4'(1 << oi3)); end
                rx_seq[oi3]++;
                for (int i = 0; i < 4; i++) begin
                    if (i != int'(oi3) && v3[i]) begin
                        waitb[i]++;
                        n_cmp++; if (waitb[i] > 9) begin n_bad++; $display("FAIL rnd_starve input %0d waited %0d beats want <= 9", i, waitb[i]); end
                    end
                end
                waitb[oi3] = 0;
                hs_idx     = int'(oi3);
                wl         = $urandom_range(0, 5);
            end
            prev_stall = ov3 && !rdy3;
            prev_idx   = oi3;
            prev_data  = od3;
            @(negedge clk);
        end
        v3   = '0;
        rdy3 = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        v1   = '0;
        v3   = '0;
        rdy1 = 1'b0;
        rdy3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d1[i] = '0;
            d3[i] = '0;
        end
        test_reset();
        test_rr_order();
        test_lock();
        test_burst();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
